load_store_unit: RTL and testbench

- Sits directly upstream of data_memory, between the execute stage and the memory port.
- Accepts one load/store request at a time over a valid/ready handshake and checks alignment.
- Drives data_memory's mem_read/mem_write/mem_size/address/write_data for the access.
- Extracts and sign- or zero-extends load data, then returns a one-cycle response to the pipeline.

---
 rtl/load_store_unit_if.sv | 37 +++
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response, memory-port and status signals of the load/store unit.
// master: pipeline plus data memory side; slave: the load/store unit itself.
interface load_store_unit_if #(
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ERR_CNT_WIDTH = 8
);
   logic                     req_valid;
   logic                     req_ready;
   logic                     req_is_store;
   logic [1:0]               req_size;
   logic                     req_unsigned;
   logic [ADDR_WIDTH-1:0]    req_addr;
   logic [DATA_WIDTH-1:0]    req_wdata;
   logic                     resp_valid;
   logic [DATA_WIDTH-1:0]    resp_rdata;
   logic                     resp_misaligned;
   logic [ERR_CNT_WIDTH-1:0] misalign_count;
   logic                     mem_read;
   logic                     mem_write;
   logic [1:0]               mem_size;
   logic [ADDR_WIDTH-1:0]    address;
   logic [DATA_WIDTH-1:0]    write_data;
   logic [DATA_WIDTH-1:0]    read_data;

   modport master (
      output req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata, read_data,
      input  req_ready, resp_valid, resp_rdata, resp_misaligned, misalign_count,
             mem_read, mem_write, mem_size, address, write_data
   );

   modport slave (
      input  req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata, read_data,
      output req_ready, resp_valid, resp_rdata, resp_misaligned, misalign_count,
             mem_read, mem_write, mem_size, address, write_data
   );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: alignment check, data_memory strobes,
// load extraction and a one-cycle response. All outputs come straight from flops.
module load_store_unit #(
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned READ_LATENCY  = 1,
   parameter int unsigned ERR_CNT_WIDTH = 8
) (
   input logic              clk,
   input logic              rst_n,
   load_store_unit_if.slave bus
);
   localparam int unsigned CNT_WIDTH = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e                   state_q, state_d;
   logic                     is_store_q, is_store_d;
   logic                     unsigned_q, unsigned_d;
   logic                     err_q, err_d;
   logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
   logic                     req_ready_q, req_ready_d;
   logic                     resp_valid_q, resp_valid_d;
   logic                     resp_misaligned_q, resp_misaligned_d;
   logic [DATA_WIDTH-1:0]    resp_rdata_q, resp_rdata_d;
   logic                     mem_read_q, mem_read_d;
   logic                     mem_write_q, mem_write_d;
   logic [1:0]               mem_size_q, mem_size_d;
   logic [ADDR_WIDTH-1:0]    address_q, address_d;
   logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
   logic [ERR_CNT_WIDTH-1:0] misalign_count_q, misalign_count_d;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      return (size == 2'b11) || (size == 2'b01 && addr_lo[0]) ||
             (size == 2'b10 && addr_lo != 2'b00);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] data,
                                                     input logic [1:0] size, input logic uns);
      case (size)
         2'b00:   return {{(DATA_WIDTH-8){~uns & data[7]}}, data[7:0]};
         2'b01:   return {{(DATA_WIDTH-16){~uns & data[15]}}, data[15:0]};
         default: return data;
      endcase
   endfunction

   function automatic logic [DATA_WIDTH-1:0] mask(input logic [DATA_WIDTH-1:0] data,
                                                   input logic [1:0] size);
      case (size)
         2'b00:   return {{(DATA_WIDTH-8){1'b0}}, data[7:0]};
         2'b01:   return {{(DATA_WIDTH-16){1'b0}}, data[15:0]};
         default: return data;
      endcase
   endfunction

   always_comb begin
      state_d          = state_q;
      is_store_d       = is_store_q;
      unsigned_d       = unsigned_q;
      err_d            = err_q;
      cnt_d            = cnt_q;
      resp_rdata_d     = resp_rdata_q;
      mem_size_d       = mem_size_q;
      address_d        = address_q;
      write_data_d     = write_data_q;
      misalign_count_d = misalign_count_q;

      case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               is_store_d = bus.req_is_store;
               unsigned_d = bus.req_unsigned;
               if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                  err_d        = 1'b1;
                  resp_rdata_d = '0;
                  state_d      = StResp;
                  if (misalign_count_q != '1) misalign_count_d = misalign_count_q + 1'b1;
               end else begin
                  err_d        = 1'b0;
                  address_d    = bus.req_addr;
                  mem_size_d   = bus.req_size;
                  write_data_d = mask(bus.req_wdata, bus.req_size);
                  state_d      = StIssue;
               end
            end
         end
         StIssue: begin
            if (is_store_q) begin
               resp_rdata_d = '0;
               state_d      = StResp;
            end else if (READ_LATENCY == 0) begin
               resp_rdata_d = extend(bus.read_data, mem_size_q, unsigned_q);
               state_d      = StResp;
            end else begin
               cnt_d   = CNT_WIDTH'(READ_LATENCY);
               state_d = StWait;
            end
         end
         StWait: begin
            if (cnt_q == CNT_WIDTH'(1)) begin
               resp_rdata_d = extend(bus.read_data, mem_size_q, unsigned_q);
               state_d      = StResp;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Strobes and flags are derived from the next state so they leave a flop.
      req_ready_d       = (state_d == StIdle);
      mem_read_d        = (state_d == StIssue || state_d == StWait) && !is_store_d;
      mem_write_d       = (state_d == StIssue) && is_store_d;
      resp_valid_d      = (state_d == StResp);
      resp_misaligned_d = (state_d == StResp) && err_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= StIdle;
         is_store_q        <= 1'b0;
         unsigned_q        <= 1'b0;
         err_q             <= 1'b0;
         cnt_q             <= '0;
         req_ready_q       <= 1'b1;
         resp_valid_q      <= 1'b0;
         resp_misaligned_q <= 1'b0;
         resp_rdata_q      <= '0;
         mem_read_q        <= 1'b0;
         mem_write_q       <= 1'b0;
         mem_size_q        <= 2'b10;
         address_q         <= '0;
         write_data_q      <= '0;
         misalign_count_q  <= '0;
      end else begin
         state_q           <= state_d;
         is_store_q        <= is_store_d;
         unsigned_q        <= unsigned_d;
         err_q             <= err_d;
         cnt_q             <= cnt_d;
         req_ready_q       <= req_ready_d;
         resp_valid_q      <= resp_valid_d;
         resp_misaligned_q <= resp_misaligned_d;
         resp_rdata_q      <= resp_rdata_d;
         mem_read_q        <= mem_read_d;
         mem_write_q       <= mem_write_d;
         mem_size_q        <= mem_size_d;
         address_q         <= address_d;
         write_data_q      <= write_data_d;
         misalign_count_q  <= misalign_count_d;
      end
   end

   assign bus.req_ready       = req_ready_q;
   assign bus.resp_valid      = resp_valid_q;
   assign bus.resp_misaligned = resp_misaligned_q;
   assign bus.resp_rdata      = resp_rdata_q;
   assign bus.mem_read        = mem_read_q;
   assign bus.mem_write       = mem_write_q;
   assign bus.mem_size        = mem_size_q;
   assign bus.address         = address_q;
   assign bus.write_data      = write_data_q;
   assign bus.misalign_count  = misalign_count_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized traffic checked
// against a byte-array reference memory and arithmetic extension rules.
module tb_load_store_unit;
   localparam int unsigned RL = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic mem_clear = 1'b1;
   always #5 clk = ~clk;

   load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ERR_CNT_WIDTH(8)) bus ();

   load_store_unit #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(RL), .ERR_CNT_WIDTH(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   logic [7:0] tb_mem [256];
   logic [7:0] ref_mem [256];
   logic [7:0] ra;
   int n_checks = 0;
   int n_pass = 0;
   int exp_cnt = 0;

   // Data memory model: little-endian bytes, low 8 address bits.
   always_comb begin
      ra = bus.address[7:0];
      bus.read_data = {tb_mem[ra + 8'd3], tb_mem[ra + 8'd2], tb_mem[ra + 8'd1], tb_mem[ra]};
   end

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 256; i++) tb_mem[i] <= 8'h00;
      end else if (bus.mem_write) begin
         for (int k = 0; k < (1 << bus.mem_size); k++)
            tb_mem[8'(bus.address[7:0] + k)] <= bus.write_data[8*k +: 8];
      end
   end

   function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a);
      int b;
      logic [7:0] p;
      p = a[7:0];
      case (sz)
         2'd0: begin
            b = int'(ref_mem[p]);
            if (!uns && b >= 128) b = b - 256;
            return 32'(b);
         end
         2'd1: begin
            b = int'(ref_mem[p]) + 256 * int'(ref_mem[p + 8'd1]);
            if (!uns && b >= 32768) b = b - 65536;
            return 32'(b);
         end
         default: return {ref_mem[p + 8'd3], ref_mem[p + 8'd2], ref_mem[p + 8'd1], ref_mem[p]};
      endcase
   endfunction

   function automatic void ref_store(input logic [1:0] sz, input logic [31:0] a,
                                     input logic [31:0] wd);
      for (int k = 0; k < (1 << sz); k++) ref_mem[8'(a[7:0] + k)] = wd[8*k +: 8];
   endfunction

   function automatic logic [31:0] ref_wmask(input logic [1:0] sz, input logic [31:0] wd);
      if (sz == 2'd2) return wd;
      return wd % (32'd1 << (8 << sz));
   endfunction

   function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd3) return 1'b1;
      return (a % (32'd1 << sz)) != 0;
   endfunction

   // Drives one request from an idle negedge and observes it until its response.
   task automatic do_req(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output int n_rd, output int n_wr,
                         output logic [31:0] rdata, output logic mis,
                         output logic [31:0] obs_addr, output logic [1:0] obs_size,
                         output logic [31:0] obs_wdata);
      bus.req_valid = 1'b1; bus.req_is_store = st; bus.req_size = sz;
      bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1; n_rd = 0; n_wr = 0; obs_addr = '0; obs_size = '0; obs_wdata = '0;
      while (1) begin
         if (bus.mem_read) begin
            n_rd++; obs_addr = bus.address; obs_size = bus.mem_size;
         end
         if (bus.mem_write) begin
            n_wr++; obs_addr = bus.address; obs_size = bus.mem_size; obs_wdata = bus.write_data;
         end
         if (bus.resp_valid === 1'b1 || lat >= 30) break;
         @(negedge clk);
         lat++;
      end
      rdata = bus.resp_rdata;
      mis = bus.resp_misaligned;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if ({bus.req_ready, bus.resp_valid, bus.resp_misaligned, bus.mem_read, bus.mem_write,
           bus.mem_size} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10})
         $display("FAIL reset_ctrl got %b exp %b", {bus.req_ready, bus.resp_valid,
                  bus.resp_misaligned, bus.mem_read, bus.mem_write, bus.mem_size}, 7'b1000010);
      else n_pass++;
      n_checks++;
      if ({bus.resp_rdata, bus.address, bus.write_data, bus.misalign_count} !== '0)
         $display("FAIL reset_data got %h %h %h %h exp 0", bus.resp_rdata, bus.address,
                  bus.write_data, bus.misalign_count);
      else n_pass++;
      rst_n = 1'b1;
      mem_clear = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.req_ready !== 1'b1) $display("FAIL ready_after_reset got %b exp 1", bus.req_ready);
      else n_pass++;
   endtask

   task automatic test_word_load();
      int lat, nr, nw; logic [31:0] rd, oa, ow; logic mis; logic [1:0] os;
      do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'h12345678, lat, nr, nw, rd, mis, oa, os, ow);
      ref_store(2'd2, 32'h8, 32'h12345678);
      n_checks++;
      if (lat !== 2 || nw !== 1) $display("FAIL wl_store got lat %0d wr %0d exp 2 1", lat, nw);
      else n_pass++;
      do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, lat, nr, nw, rd, mis, oa, os, ow);
      n_checks++;
      if (lat !== RL + 2) $display("FAIL wl_latency got %0d exp %0d", lat, RL + 2);
      else n_pass++;
      n_checks++;
      if (nr !== RL + 1 || nw !== 0)
         $display("FAIL wl_strobes got rd %0d wr %0d exp %0d 0", nr, nw, RL + 1);
      else n_pass++;
      n_checks++;
      if (oa !== 32'h8 || os !== 2'b10) $display("FAIL wl_addr got %h/%b exp 8/10", oa, os);
      else n_pass++;
      n_checks++;
      if (rd !== 32'h12345678 || mis !== 1'b0)
         $display("FAIL wl_rdata got %h mis %b exp 12345678 0", rd, mis);
      else n_pass++;
   endtask

   task automatic test_store_loads(input logic [1:0] sz, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] exp_wd,
                                   input logic [31:0] exp_s, input logic [31:0] exp_u);
      int lat, nr, nw; logic [31:0] rd, oa, ow; logic mis; logic [1:0] os;
      do_req(1'b1, sz, 1'b0, a, wd, lat, nr, nw, rd, mis, oa, os, ow);
      ref_store(sz, a, wd);
      n_checks++;
      if (ow !== exp_wd || os !== sz || oa !== a || nw !== 1)
         $display("FAIL st_bus got wd %h sz %b a %h wr %0d exp %h %b %h 1", ow, os, oa, nw,
                  exp_wd, sz, a);
      else n_pass++;
      n_checks++;
      if (lat !== 2 || rd !== 0) $display("FAIL st_resp got lat %0d rd %h exp 2 0", lat, rd);
      else n_pass++;
      do_req(1'b0, sz, 1'b0, a, 32'h0, lat, nr, nw, rd, mis, oa, os, ow);
      n_checks++;
      if (rd !== exp_s) $display("FAIL ld_signed got %h exp %h", rd, exp_s);
      else n_pass++;
      do_req(1'b0, sz, 1'b1, a, 32'h0, lat, nr, nw, rd, mis, oa, os, ow);
      n_checks++;
      if (rd !== exp_u) $display("FAIL ld_unsigned got %h exp %h", rd, exp_u);
      else n_pass++;
   endtask

   task automatic test_misalign();
      int lat, nr, nw, bad; logic [31:0] rd, oa, ow, wd; logic mis; logic [1:0] os, sz;
      wd = $urandom();
      do_req(1'b1, 2'd2, 1'b0, 32'h14, wd, lat, nr, nw, rd, mis, oa, os, ow);
      ref_store(2'd2, 32'h14, wd);
      n_checks++;
      if (lat !== 2 || mis !== 1'b0 || nw !== 1)
         $display("FAIL ma_first got lat %0d mis %b wr %0d exp 2 0 1", lat, mis, nw);
      else n_pass++;
      do_req(1'b0, 2'd2, 1'b0, 32'h16, 32'h0, lat, nr, nw, rd, mis, oa, os, ow);
      exp_cnt = 1;
      n_checks++;
      if (lat !== 1 || mis !== 1'b1 || rd !== 0)
         $display("FAIL ma_resp got lat %0d mis %b rd %h exp 1 1 0", lat, mis, rd);
      else n_pass++;
      n_checks++;
      if (nr + nw !== 0) $display("FAIL ma_strobe got %0d exp 0", nr + nw);
      else n_pass++;
      n_checks++;
      if (bus.misalign_count !== 8'(exp_cnt))
         $display("FAIL ma_count1 got %0d exp %0d", bus.misalign_count, exp_cnt);
      else n_pass++;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         sz = 2'($urandom_range(1, 3));
         wd = $urandom();
         if (sz != 2'd3) wd[0] = 1'b1;
         do_req(1'($urandom_range(0, 1)), sz, 1'b0, wd, $urandom(), lat, nr, nw, rd, mis,
                oa, os, ow);
         if (exp_cnt < 255) exp_cnt++;
         if (lat != 1 || mis != 1'b1 || nr + nw != 0) bad++;
      end
      n_checks++;
      if (bad !== 0) $display("FAIL ma_bulk got %0d bad responses exp 0", bad);
      else n_pass++;
      n_checks++;
      if (bus.misalign_count !== 8'(exp_cnt))
         $display("FAIL ma_saturate got %h exp %h", bus.misalign_count, 8'(exp_cnt));
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [5:0] rdy_tr, vld_tr, wr_tr;
      logic [31:0] wa, wb, ow [2];
      int nwr;
      wa = $urandom(); wb = $urandom(); nwr = 0;
      bus.req_valid = 1'b1; bus.req_is_store = 1'b1; bus.req_size = 2'd0;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'h20; bus.req_wdata = wa;
      @(posedge clk);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         rdy_tr[i-1] = bus.req_ready;
         vld_tr[i-1] = bus.resp_valid;
         wr_tr[i-1] = bus.mem_write;
         if (bus.mem_write && nwr < 2) begin
            ow[nwr] = bus.write_data; nwr++;
         end
         if (i == 1) begin
            bus.req_size = 2'd1; bus.req_addr = 32'h22; bus.req_wdata = wb;
         end
         if (i == 4) bus.req_valid = 1'b0;
      end
      ref_store(2'd0, 32'h20, wa);
      ref_store(2'd1, 32'h22, wb);
      n_checks++;
      if (rdy_tr !== 6'b100100) $display("FAIL b2b_ready got %b exp 100100", rdy_tr);
      else n_pass++;
      n_checks++;
      if (vld_tr !== 6'b010010) $display("FAIL b2b_resp got %b exp 010010", vld_tr);
      else n_pass++;
      n_checks++;
      if (wr_tr !== 6'b001001) $display("FAIL b2b_write got %b exp 001001", wr_tr);
      else n_pass++;
      n_checks++;
      if (nwr !== 2 || ow[0] !== ref_wmask(2'd0, wa) || ow[1] !== ref_wmask(2'd1, wb))
         $display("FAIL b2b_wdata got %0d %h %h exp 2 %h %h", nwr, ow[0], ow[1],
                  ref_wmask(2'd0, wa), ref_wmask(2'd1, wb));
      else n_pass++;
   endtask

   task automatic test_random();
      int lat, nr, nw, exp_lat, exp_rd_n, exp_wr_n;
      logic [31:0] rd, oa, ow, a, wd, exp_rd, r;
      logic mis, st, uns, emis;
      logic [1:0] os, sz;
      for (int i = 0; i < 80; i++) begin
         st = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
         wd = $urandom(); r = $urandom();
         if ($urandom_range(0, 7) == 0) begin
            sz = 2'($urandom_range(1, 3));
            a = {r[31:8], 8'($urandom_range(0, 63))};
            if (sz != 2'd3) a[0] = 1'b1;
         end else begin
            sz = 2'($urandom_range(0, 2));
            a = {r[31:8], 8'($urandom_range(0, 63))};
            a = a - (a % (32'd1 << sz));
         end
         emis = ref_mis(sz, a);
         exp_lat = emis ? 1 : (st ? 2 : RL + 2);
         exp_rd = (emis || st) ? 32'h0 : ref_load(sz, uns, a);
         exp_rd_n = (!emis && !st) ? RL + 1 : 0;
         exp_wr_n = (!emis && st) ? 1 : 0;
         if (emis && exp_cnt < 255) exp_cnt++;
         do_req(st, sz, uns, a, wd, lat, nr, nw, rd, mis, oa, os, ow);
         if (!emis && st) ref_store(sz, a, wd);
         n_checks++;
         if (lat !== exp_lat) $display("FAIL rnd_lat[%0d] got %0d exp %0d", i, lat, exp_lat);
         else n_pass++;
         n_checks++;
         if (rd !== exp_rd || mis !== emis)
            $display("FAIL rnd_resp[%0d] got %h/%b exp %h/%b", i, rd, mis, exp_rd, emis);
         else n_pass++;
         n_checks++;
         if (nr !== exp_rd_n || nw !== exp_wr_n)
            $display("FAIL rnd_strobe[%0d] got %0d/%0d exp %0d/%0d", i, nr, nw, exp_rd_n,
                     exp_wr_n);
         else n_pass++;
         if (!emis) begin
            n_checks++;
            if (oa !== a || os !== sz || (st && ow !== ref_wmask(sz, wd)))
               $display("FAIL rnd_bus[%0d] got %h/%b/%h exp %h/%b/%h", i, oa, os, ow, a, sz,
                        ref_wmask(sz, wd));
            else n_pass++;
         end
         n_checks++;
         if (bus.misalign_count !== 8'(exp_cnt))
            $display("FAIL rnd_count[%0d] got %0d exp %0d", i, bus.misalign_count, exp_cnt);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_load();
      int bad;
      bus.req_valid = 1'b1; bus.req_is_store = 1'b0; bus.req_size = 2'd2;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'h8; bus.req_wdata = 32'h0;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.mem_read !== 1'b1) $display("FAIL rml_wait got %b exp 1", bus.mem_read);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      exp_cnt = 0;
      n_checks++;
      if ({bus.mem_read, bus.mem_write, bus.resp_valid, bus.req_ready} !== 4'b0001 ||
          bus.misalign_count !== 8'(exp_cnt))
         $display("FAIL rml_clear got %b cnt %0d exp 0001 cnt 0", {bus.mem_read, bus.mem_write,
                  bus.resp_valid, bus.req_ready}, bus.misalign_count);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.resp_valid || !bus.req_ready || bus.mem_read) bad++;
      end
      n_checks++;
      if (bad !== 0) $display("FAIL rml_after got %0d bad cycles exp 0", bad);
      else n_pass++;
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_size = 2'd0;
      bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      @(negedge clk);
      test_reset();
      test_word_load();
      test_store_loads(2'd0, 32'h10, 32'h000000AB, 32'h000000AB, 32'hFFFFFFAB, 32'h000000AB);
      test_store_loads(2'd1, 32'h12, 32'hFFFFCDEF, 32'h0000CDEF, 32'hFFFFCDEF, 32'h0000CDEF);
      test_misalign();
      test_back_to_back();
      test_random();
      test_reset_mid_load();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
